// File: rtl/memorio_bridge.sv
// memorio_bridge: bridges the CPU datapath to data memory and NCH IO channels.
// Memory accesses pass straight through. IO accesses go through a small wait-state
// FSM (IDLE -> WAIT -> DONE) with a per-channel ready handshake and a timeout.
// Optional feature macro: MEMORIO_READ_SEXT_EN (sign-extend IO read data into rdata).
module memorio_bridge #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned IOW     = 16,
   parameter int unsigned CH_LSB  = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic [31:0]          i_caddress,
   input  logic                 i_memread,
   input  logic                 i_memwrite,
   input  logic                 i_ioread,
   input  logic                 i_iowrite,
   input  logic [31:0]          i_wdata,
   input  logic [31:0]          i_mread_data,
   input  logic [NCH*IOW-1:0]   i_ioread_data,
   input  logic [NCH-1:0]       i_ioready,
   output logic [31:0]          o_address,
   output logic [31:0]          o_write_data,
   output logic [31:0]          o_rdata,
   output logic [NCH-1:0]       o_io_cs,
   output logic                 o_io_we,
   output logic                 o_stall,
   output logic                 o_err
);

   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

`ifdef MEMORIO_READ_SEXT_EN
   localparam bit SEXT_EN = 1'b1;
`else
   localparam bit SEXT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [CHW-1:0]   r_ch;
   logic [31:0]      r_addr;
   logic [IOW-1:0]   r_wdata;
   logic [IOW-1:0]   r_data;
   logic             r_dir;
   logic [7:0]       r_cnt;
   logic             r_err;

   logic [CHW-1:0]   w_ch;
   logic             w_ch_ok;
   logic             w_mem_req;
   logic             w_io_req;
   logic             w_latch;
   logic [7:0]       w_cnt_next;
   logic [IOW-1:0]   w_data_next;
   logic             w_err_next;
   logic             w_ready_sel;
   logic [IOW-1:0]   w_rd_sel;
   logic [31:0]      w_rdata_ext;
   logic [31:0]      w_wdata_ext;

   assign w_ch        = i_caddress[CH_LSB +: CHW];
   assign w_ch_ok     = ({1'b0, w_ch} < NCH_W);
   assign w_mem_req   = i_memread | i_memwrite;
   assign w_io_req    = i_ioread | i_iowrite;
   // Only the latched channel's ready/data matter; other channels are ignored.
   assign w_ready_sel = i_ioready[r_ch];
   assign w_rd_sel    = i_ioread_data[r_ch*IOW +: IOW];

   // Widen latched IO data to 32 bits (zero- or sign-extended read data, zero-extended store data).
   always_comb begin
      w_rdata_ext = '0;
      w_rdata_ext[IOW-1:0] = r_data;
      if (SEXT_EN) begin
         for (int i = IOW; i < 32; i++) begin
            w_rdata_ext[i] = r_data[IOW-1];
         end
      end
      w_wdata_ext = '0;
      w_wdata_ext[IOW-1:0] = r_wdata;
   end

   // Next-state logic: request decode, wait counter, data capture and error pulse.
   always_comb begin
      w_state_next = r_state;
      w_latch      = 1'b0;
      w_cnt_next   = r_cnt;
      w_data_next  = r_data;
      w_err_next   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_mem_req) begin
               // Memory wins a conflict; the IO request is dropped and flagged.
               w_err_next = w_io_req;
            end else if (w_io_req) begin
               w_latch     = 1'b1;
               w_cnt_next  = '0;
               w_data_next = '0;
               if (w_ch_ok) begin
                  w_state_next = StWait;
               end else begin
                  w_state_next = StDone;
                  w_err_next   = 1'b1;
               end
            end
         end
         StWait: begin
            if (w_ready_sel) begin
               w_state_next = StDone;
               w_data_next  = r_dir ? '0 : w_rd_sel;
            end else if (r_cnt == CNT_LAST) begin
               w_state_next = StDone;
               w_data_next  = '0;
               w_err_next   = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         StDone: begin
            // The completing instruction's request is still high here; ignore it.
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // State register and latched access fields, synchronous reset.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_ch    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_dir   <= 1'b0;
         r_data  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_data  <= w_data_next;
         r_cnt   <= w_cnt_next;
         r_err   <= w_err_next;
         if (w_latch) begin
            r_ch    <= w_ch;
            r_addr  <= i_caddress;
            r_wdata <= i_wdata[IOW-1:0];
            r_dir   <= i_iowrite;
         end
      end
   end

   // Output decode: memory pass-through in IDLE, IO strobes in WAIT, read-back in DONE.
   always_comb begin
      o_address    = i_caddress;
      o_write_data = '0;
      o_rdata      = '0;
      o_io_cs      = '0;
      o_io_we      = 1'b0;
      o_stall      = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_mem_req) begin
               o_write_data = i_memwrite ? i_wdata : '0;
               o_rdata      = i_memread ? i_mread_data : '0;
            end else if (w_io_req) begin
               o_stall = 1'b1;
            end
         end
         StWait: begin
            o_stall       = 1'b1;
            o_io_cs[r_ch] = 1'b1;
            o_io_we       = r_dir;
            o_address     = r_addr;
            o_write_data  = r_dir ? w_wdata_ext : '0;
         end
         StDone: begin
            o_address = r_addr;
            o_rdata   = r_dir ? '0 : w_rdata_ext;
         end
         default: begin
            o_stall = 1'b0;
         end
      endcase
   end

   assign o_err = r_err;

endmodule
